// File: rtl/n1_pbus_pkg.sv
// Shared pbus definitions: pending-request entry, responder FSM states and the
// tag bit positions used by both the N1 core initiator and this responder.
package n1_pbus_pkg;

  localparam int TGA_JMP = 0;
  localparam int TGA_CAL = 1;
  localparam int TGA_BRA = 2;
  localparam int TGA_EOW = 3;
  localparam int TGA_DAT = 4;
  localparam int TGA_W   = 5;

  typedef struct packed {
    logic [15:0]      adr;
    logic             we;
    logic [15:0]      dat;
    logic [TGA_W-1:0] tga;
  } pend_t;

  localparam int PEND_W = $bits(pend_t);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCESS,
    ST_RESP
  } state_t;

  function automatic logic has_cof(input logic [TGA_W-1:0] tga);
    return |tga[TGA_EOW:TGA_JMP];
  endfunction

endpackage

// File: rtl/n1_pbus_fifo.sv
// PEND-deep synchronous request queue with occupancy count and flush.
// Entries are carried as flat vectors; the occupancy count is registered.
module n1_pbus_fifo
  import n1_pbus_pkg::*;
#(
  parameter int PEND = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    flush,
  input  logic                    push,
  input  logic [PEND_W-1:0]       push_data,
  input  logic                    pop,
  output logic [PEND_W-1:0]       head,
  output logic                    empty,
  output logic                    full,
  output logic [$clog2(PEND):0]   cnt
);

  localparam int PW = $clog2(PEND);
  localparam logic [PW:0] FULL_CNT = (PW + 1)'(PEND);

  logic [PEND_W-1:0] store [PEND];
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;

  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      cnt <= cnt + {{PW{1'b0}}, push} - {{PW{1'b0}}, pop};
    end
  end

  always_ff @(posedge clk) begin
    if (push) store[wr_ptr] <= push_data;
  end

  assign head  = store[rd_ptr];
  assign empty = (cnt == '0);
  assign full  = (cnt == FULL_CNT);

endmodule

// File: rtl/n1_pbus_responder.sv
// Pipelined Wishbone program-bus target for the N1 core: queues requests, serves
// them in order from on-chip memory with programmable wait states.
module n1_pbus_responder
  import n1_pbus_pkg::*;
#(
  parameter int DEPTH    = 256,
  parameter int WAIT_CYC = 0,
  parameter int PEND     = 2
) (
  input  logic        clk_i,
  input  logic        sync_rst_i,
  input  logic        pbus_cyc_i,
  input  logic        pbus_stb_i,
  input  logic        pbus_we_i,
  input  logic [15:0] pbus_adr_i,
  input  logic [15:0] pbus_dat_i,
  input  logic        pbus_tga_cof_jmp_i,
  input  logic        pbus_tga_cof_cal_i,
  input  logic        pbus_tga_cof_bra_i,
  input  logic        pbus_tga_cof_eow_i,
  input  logic        pbus_tga_dat_i,
  output logic        pbus_ack_o,
  output logic        pbus_err_o,
  output logic        pbus_stall_o,
  output logic [15:0] pbus_dat_o,
  output logic [15:0] prb_cof_cnt_o
);

  localparam int          AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int          CW        = $clog2(PEND) + 1;
  localparam logic [3:0]  WAIT_LD   = 4'(WAIT_CYC);
  localparam logic [16:0] DEPTH_LIM = 17'(DEPTH);

  logic [15:0]       mem [DEPTH];
  state_t            state;
  state_t            state_nxt;
  logic [3:0]        wait_cnt;
  logic [3:0]        wait_nxt;
  logic              accept;
  logic              commit;
  logic              pop;
  logic              empty;
  logic              full;
  logic              bad;
  logic [CW-1:0]     cnt;
  logic [PEND_W-1:0] head_bits;
  pend_t             req;
  pend_t             head;
  logic              ack_q;
  logic              err_q;
  logic [15:0]       dat_q;
  logic [15:0]       cof_cnt;

  assign accept = pbus_cyc_i & pbus_stb_i & ~full;
  assign req    = {pbus_adr_i, pbus_we_i, pbus_dat_i, pbus_tga_dat_i, pbus_tga_cof_eow_i,
                   pbus_tga_cof_bra_i, pbus_tga_cof_cal_i, pbus_tga_cof_jmp_i};
  assign head   = pend_t'(head_bits);
  assign bad    = ({1'b0, head.adr} >= DEPTH_LIM) | (head.we & ~head.tga[TGA_DAT]);

  // Dropping cyc flushes the queue in the same edge the FSM returns to IDLE.
  n1_pbus_fifo #(
    .PEND (PEND)
  ) u_fifo (
    .clk       (clk_i),
    .rst_n     (sync_rst_i),
    .flush     (~pbus_cyc_i),
    .push      (accept),
    .push_data (req),
    .pop       (pop),
    .head      (head_bits),
    .empty     (empty),
    .full      (full),
    .cnt       (cnt)
  );

  always_ff @(posedge clk_i) begin
    if (!sync_rst_i) begin
      state    <= ST_IDLE;
      wait_cnt <= '0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    wait_nxt  = wait_cnt;
    commit    = 1'b0;
    pop       = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!empty) begin
          state_nxt = ST_ACCESS;
          wait_nxt  = WAIT_LD;
        end
      end
      ST_ACCESS: begin
        if (wait_cnt == '0) begin
          state_nxt = ST_RESP;
          commit    = 1'b1;
        end else begin
          wait_nxt = wait_cnt - 4'd1;
        end
      end
      ST_RESP: begin
        pop = 1'b1;
        if ((cnt > CW'(1)) || accept) begin
          state_nxt = ST_ACCESS;
          wait_nxt  = WAIT_LD;
        end else begin
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
    if (!pbus_cyc_i) begin
      state_nxt = ST_IDLE;
      commit    = 1'b0;
      pop       = 1'b0;
    end
  end

  // Access commits on entry to RESP, so a later queued read sees earlier writes.
  always_ff @(posedge clk_i) begin
    if (sync_rst_i && commit && !bad && head.we) mem[head.adr[AW-1:0]] <= head.dat;
  end

  always_ff @(posedge clk_i) begin
    if (!sync_rst_i) begin
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      dat_q   <= '0;
      cof_cnt <= '0;
    end else begin
      ack_q <= commit & ~bad;
      err_q <= commit & bad;
      if (commit && !bad && !head.we) dat_q <= mem[head.adr[AW-1:0]];
      else                            dat_q <= '0;
      if ((state == ST_RESP) && ack_q && pbus_cyc_i && has_cof(head.tga))
        cof_cnt <= cof_cnt + 16'd1;
    end
  end

  assign pbus_ack_o    = ack_q & pbus_cyc_i;
  assign pbus_err_o    = err_q & pbus_cyc_i;
  assign pbus_stall_o  = full;
  assign pbus_dat_o    = dat_q;
  assign prb_cof_cnt_o = cof_cnt;

endmodule

// File: tb/tb_n1_pbus_responder.sv
// Directed bench for n1_pbus_responder: two instances (WAIT_CYC 0 and 3) share
// request inputs, selected by their own cyc; a scoreboard checks every response.
module tb_n1_pbus_responder;

  typedef struct packed {
    logic        err;
    logic [15:0] dat;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cyc0, cyc3;
  logic        stb, we;
  logic [15:0] adr, wdat;
  logic [4:0]  tga;
  logic        ack0, err0, stall0, ack3, err3, stall3;
  logic [15:0] rdat0, rdat3, cof0, cof3;

  int   tests = 0;
  int   fails = 0;
  int   cyc_n = 0;
  int   last_acc;
  int   t0;
  int   n_before;
  logic sel;
  exp_t expq[$];
  int   rtq[$];
  logic [15:0] mdl [2][256];

  always #5 clk = ~clk;
  always @(posedge clk) cyc_n <= cyc_n + 1;

  n1_pbus_responder #(.DEPTH(256), .WAIT_CYC(0), .PEND(2)) u0 (
    .clk_i(clk), .sync_rst_i(rst_n), .pbus_cyc_i(cyc0), .pbus_stb_i(stb), .pbus_we_i(we),
    .pbus_adr_i(adr), .pbus_dat_i(wdat), .pbus_tga_cof_jmp_i(tga[0]), .pbus_tga_cof_cal_i(tga[1]),
    .pbus_tga_cof_bra_i(tga[2]), .pbus_tga_cof_eow_i(tga[3]), .pbus_tga_dat_i(tga[4]),
    .pbus_ack_o(ack0), .pbus_err_o(err0), .pbus_stall_o(stall0), .pbus_dat_o(rdat0),
    .prb_cof_cnt_o(cof0));

  n1_pbus_responder #(.DEPTH(256), .WAIT_CYC(3), .PEND(2)) u3 (
    .clk_i(clk), .sync_rst_i(rst_n), .pbus_cyc_i(cyc3), .pbus_stb_i(stb), .pbus_we_i(we),
    .pbus_adr_i(adr), .pbus_dat_i(wdat), .pbus_tga_cof_jmp_i(tga[0]), .pbus_tga_cof_cal_i(tga[1]),
    .pbus_tga_cof_bra_i(tga[2]), .pbus_tga_cof_eow_i(tga[3]), .pbus_tga_dat_i(tga[4]),
    .pbus_ack_o(ack3), .pbus_err_o(err3), .pbus_stall_o(stall3), .pbus_dat_o(rdat3),
    .prb_cof_cnt_o(cof3));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv)
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Response monitor for the selected instance, sampled on the falling edge.
  logic        m_ack, m_err;
  logic [15:0] m_dat;
  exp_t        m_exp;
  always @(negedge clk) begin
    m_ack = sel ? ack3 : ack0;
    m_err = sel ? err3 : err0;
    m_dat = sel ? rdat3 : rdat0;
    if (rst_n === 1'b1 && (m_ack || m_err)) begin
      rtq.push_back(cyc_n);
      if (expq.size() == 0) begin
        check("unexpected_resp", {30'd0, m_ack, m_err}, 32'd0);
      end else begin
        m_exp = expq.pop_front();
        check("resp", {14'd0, m_ack, m_err, m_dat}, {14'd0, ~m_exp.err, m_exp.err, m_exp.dat});
      end
    end
  end

  task automatic issue(input logic s, input logic [15:0] a, input logic w,
                       input logic [15:0] d, input logic [4:0] t);
    logic st;
    int   n;
    exp_t e;
    stb = 1'b1; we = w; adr = a; wdat = d; tga = t;
    n = 0;
    forever begin
      @(negedge clk);
      st = s ? stall3 : stall0;
      @(posedge clk);
      if (!st) break;
      n++;
      if (n > 50) begin
        tests++;
        fails++;
        $error("FAIL accept_timeout observed=stalled expected=accepted adr=%0h", a);
        stb = 1'b0;
        return;
      end
    end
    #1;
    last_acc = cyc_n;
    e.err = (a >= 16'd256) || (w && !t[4]);
    e.dat = 16'h0000;
    if (!e.err) begin
      if (w) mdl[s][a[7:0]] = d;
      else   e.dat = mdl[s][a[7:0]];
    end
    expq.push_back(e);
  endtask

  task automatic idle();
    stb = 1'b0; we = 1'b0; tga = 5'd0;
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while (expq.size() != 0 && n < budget) begin
      @(posedge clk);
      n++;
    end
    check("drain_timeout", expq.size(), 0);
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    sel = 1'b0; rst_n = 1'b0; cyc0 = 1'b1; cyc3 = 1'b1;
    stb = 1'b1; we = 1'b0; adr = 16'h0010; wdat = 16'h0000; tga = 5'd0;

    // 1: reset with a live strobe
    repeat (3) @(posedge clk);
    #1;
    check("rst_u0_ctl", {29'd0, ack0, err0, stall0}, 32'd0);
    check("rst_u0_dat", rdat0, 32'd0);
    check("rst_u0_cof", cof0, 32'd0);
    check("rst_u3_ctl", {29'd0, ack3, err3, stall3}, 32'd0);
    check("rst_u3_dat", rdat3, 32'd0);
    stb = 1'b0;
    rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check("rst_no_accept", rtq.size(), 0);
    check("rst_stall_after", {30'd0, stall0, stall3}, 32'd0);

    // 2: write then read back, WAIT_CYC=0
    cyc3 = 1'b0;
    rtq.delete();
    issue(1'b0, 16'h0010, 1'b1, 16'hBEEF, 5'b10000);
    t0 = last_acc;
    issue(1'b0, 16'h0010, 1'b0, 16'h0000, 5'b00000);
    idle();
    drain(30);
    check("t2_nresp", rtq.size(), 2);
    check("t2_ack1_time", rtq[0], t0 + 2);
    check("t2_ack2_time", rtq[1], t0 + 4);

    // 3: WAIT_CYC=3 back-to-back reads, queue fills after two accepts
    sel = 1'b1; cyc0 = 1'b0; cyc3 = 1'b1;
    for (int i = 0; i < 4; i++) issue(1'b1, 16'h0040 + 16'(i), 1'b1, 16'hA000 + 16'(i), 5'b10000);
    idle();
    drain(100);
    rtq.delete();
    issue(1'b1, 16'h0043, 1'b0, 16'h0000, 5'b00000);
    t0 = last_acc;
    issue(1'b1, 16'h0041, 1'b0, 16'h0000, 5'b00100);
    check("t3_stall_full", {31'd0, stall3}, 32'd1);
    issue(1'b1, 16'h0040, 1'b0, 16'h0000, 5'b00000);
    issue(1'b1, 16'h0042, 1'b0, 16'h0000, 5'b00010);
    idle();
    drain(100);
    check("t3_nresp", rtq.size(), 4);
    check("t3_first_lat", rtq[0], t0 + 5);
    for (int i = 1; i < 4; i++) check("t3_spacing", rtq[i] - rtq[i-1], 5);

    // 4: untagged write and out-of-range read both terminate with err
    sel = 1'b0; cyc3 = 1'b0; cyc0 = 1'b1;
    issue(1'b0, 16'h0020, 1'b1, 16'h1234, 5'b10000);
    issue(1'b0, 16'h0020, 1'b1, 16'h5555, 5'b00000);
    issue(1'b0, 16'h0020, 1'b0, 16'h0000, 5'b00000);
    issue(1'b0, 16'h0100, 1'b0, 16'h0000, 5'b00000);
    idle();
    drain(40);

    // 5: cyc dropped during ACCESS with two pending
    sel = 1'b1; cyc0 = 1'b0; cyc3 = 1'b1;
    n_before = rtq.size();
    issue(1'b1, 16'h0040, 1'b0, 16'h0000, 5'b00000);
    issue(1'b1, 16'h0041, 1'b0, 16'h0000, 5'b00000);
    idle();
    @(posedge clk);
    #1;
    cyc3 = 1'b0;
    expq.delete();
    @(posedge clk);
    #1;
    check("t5_stall_flushed", {31'd0, stall3}, 32'd0);
    check("t5_no_term", {30'd0, ack3, err3}, 32'd0);
    cyc3 = 1'b1;
    repeat (12) @(posedge clk);
    #1;
    check("t5_no_resp", rtq.size(), n_before);

    // 6: COF-tagged fetches counted
    sel = 1'b0; cyc3 = 1'b0; cyc0 = 1'b1;
    check("t6_cof_start", cof0, 32'd0);
    issue(1'b0, 16'h0010, 1'b0, 16'h0000, 5'b00001);
    issue(1'b0, 16'h0010, 1'b0, 16'h0000, 5'b01000);
    issue(1'b0, 16'h0010, 1'b0, 16'h0000, 5'b00000);
    idle();
    drain(40);
    check("t6_cof_cnt", cof0, 32'd2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
